// File: rtl/arty_boot_pkg.sv
// Arty boot controller shared types and defaults.
// Holds the boot FSM state enum and default timing constants.
package arty_boot_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK  = 2'd0,
    HOLD_RST   = 2'd1,
    WAIT_FETCH = 2'd2,
    RUN        = 2'd3
  } boot_state_e;

  localparam int LOCK_STABLE_DEF = 1024;
  localparam int RST_HOLD_DEF    = 16;
  localparam int DEBOUNCE_DEF    = 500000;

endpackage

// File: rtl/arty_boot_if.sv
// Board-side signal bundle of the Arty boot controller.
// master: boot controller (drives SoC reset/fetch/status); slave: board/SoC.
interface arty_boot_if;

  logic       pll_locked_i;
  logic       fetch_sw_i;
  logic       soc_rst_n_o;
  logic       fetch_enable_o;
  logic [1:0] boot_state_o;
  logic       lock_lost_o;

  modport master (
    input  pll_locked_i,
    input  fetch_sw_i,
    output soc_rst_n_o,
    output fetch_enable_o,
    output boot_state_o,
    output lock_lost_o
  );

  modport slave (
    output pll_locked_i,
    output fetch_sw_i,
    input  soc_rst_n_o,
    input  fetch_enable_o,
    input  boot_state_o,
    input  lock_lost_o
  );

endinterface

// File: rtl/arty_debounce.sv
// 2-flop synchronizer plus saturating debounce counter for a switch.
// Ports: clk, rst (sync, high), sw_i (async, bouncing), level_o (debounced).
module arty_debounce
  import arty_boot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_i,
  output logic level_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);

  logic          sw_meta;
  logic          sw_s;
  logic          level_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = (cnt_q == CMAX) ? cnt_q : cnt_q + 1'b1;

  // The level flips on the cycle the mismatch run reaches the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta <= 1'b0;
      sw_s    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sw_meta <= sw_i;
      sw_s    <= sw_meta;
      if (sw_s == level_q) begin
        cnt_q <= '0;
      end else if (cnt_inc == CMAX) begin
        level_q <= sw_s;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_inc;
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/arty_boot_ctrl.sv
// Arty SoC boot sequencer: lock qualify, reset hold, debounced fetch.
// Ports: clk, rst (sync, high), io (arty_boot_if.master).
module arty_boot_ctrl
  import arty_boot_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = LOCK_STABLE_DEF,
  parameter int RST_HOLD_CYCLES    = RST_HOLD_DEF,
  parameter int DEBOUNCE_CYCLES    = DEBOUNCE_DEF
) (
  input  logic         clk,
  input  logic         rst,
  arty_boot_if.master  io
);

  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [SW-1:0] SMAX = SW'(LOCK_STABLE_CYCLES);
  localparam logic [HW-1:0] HMAX = HW'(RST_HOLD_CYCLES);

  boot_state_e   state_q;
  boot_state_e   state_d;
  logic          lock_meta;
  logic          lock_s;
  logic          fetch_db;
  logic [SW-1:0] stable_q;
  logic [SW-1:0] stable_d;
  logic [SW-1:0] stable_inc;
  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;
  logic [HW-1:0] hold_inc;
  logic          lost_q;
  logic          lost_d;
  logic          soc_rst_n_q;
  logic          fetch_en_q;

  arty_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_fetch_db (
    .clk    (clk),
    .rst    (rst),
    .sw_i   (io.fetch_sw_i),
    .level_o(fetch_db)
  );

  assign stable_inc = (stable_q == SMAX) ? stable_q : stable_q + 1'b1;
  assign hold_inc   = (hold_q == HMAX) ? hold_q : hold_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    hold_d   = hold_q;
    lost_d   = lost_q;
    unique case (state_q)
      WAIT_LOCK: begin
        if (!lock_s) begin
          stable_d = '0;
        end else if (stable_inc == SMAX) begin
          state_d  = HOLD_RST;
          stable_d = '0;
        end else begin
          stable_d = stable_inc;
        end
      end
      HOLD_RST: begin
        if (hold_inc == HMAX) begin
          state_d = WAIT_FETCH;
          hold_d  = '0;
        end else begin
          hold_d = hold_inc;
        end
      end
      WAIT_FETCH: begin
        if (fetch_db) state_d = RUN;
      end
      RUN: begin
        if (!fetch_db) state_d = WAIT_FETCH;
      end
    endcase
    // Losing lock after acceptance overrides any transition above.
    if (state_q != WAIT_LOCK && !lock_s) begin
      state_d  = WAIT_LOCK;
      stable_d = '0;
      hold_d   = '0;
      lost_d   = 1'b1;
    end
  end

  // Outputs decode the next state so they change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_meta   <= 1'b0;
      lock_s      <= 1'b0;
      state_q     <= WAIT_LOCK;
      stable_q    <= '0;
      hold_q      <= '0;
      lost_q      <= 1'b0;
      soc_rst_n_q <= 1'b0;
      fetch_en_q  <= 1'b0;
    end else begin
      lock_meta   <= io.pll_locked_i;
      lock_s      <= lock_meta;
      state_q     <= state_d;
      stable_q    <= stable_d;
      hold_q      <= hold_d;
      lost_q      <= lost_d;
      soc_rst_n_q <= (state_d == WAIT_FETCH) || (state_d == RUN);
      fetch_en_q  <= (state_d == RUN);
    end
  end

  assign io.soc_rst_n_o    = soc_rst_n_q;
  assign io.fetch_enable_o = fetch_en_q;
  assign io.boot_state_o   = state_q;
  assign io.lock_lost_o    = lost_q;

endmodule

// File: tb/tb_arty_boot_ctrl.sv
// Self-checking bench for arty_boot_ctrl (L=8, H=4, D=5).
// Run-length/window reference model plus directed edge checks.
module tb_arty_boot_ctrl;

  localparam int L = 8;
  localparam int H = 4;
  localparam int D = 5;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  arty_boot_if io ();

  arty_boot_ctrl #(
    .LOCK_STABLE_CYCLES(L),
    .RST_HOLD_CYCLES   (H),
    .DEBOUNCE_CYCLES   (D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  always #5 clk = ~clk;

  // Reference model: inputs sampled per edge since reset release.
  logic       lkq[$];
  logic       swq[$];
  int         n;
  int         run;
  logic       db;
  logic       lost;
  logic       ex_rst_n;
  logic       ex_fetch;
  logic [1:0] ex_state;

  function automatic logic [4:0] obs();
    return {io.soc_rst_n_o, io.fetch_enable_o,
            io.boot_state_o, io.lock_lost_o};
  endfunction

  function automatic logic [4:0] expv();
    return {ex_rst_n, ex_fetch, ex_state, lost};
  endfunction

  task automatic tick();
    logic s_lk;
    logic s_sw;
    logic db_b;
    logic up_b;
    logic flip;
    lkq.push_back(io.pll_locked_i);
    swq.push_back(io.fetch_sw_i);
    @(posedge clk);
    if (rst) begin
      n = 0;
      run = 0;
      db = 1'b0;
      lost = 1'b0;
      lkq.delete();
      swq.delete();
      ex_rst_n = 1'b0;
      ex_fetch = 1'b0;
      ex_state = 2'd0;
    end else begin
      n++;
      // Synchronized value seen at edge k is the input from edge k-2.
      s_lk = (n >= 3) ? lkq[n-3] : 1'b0;
      db_b = db;
      up_b = (run >= L + H);
      if (!s_lk) begin
        if (run >= L) lost = 1'b1;
        run = 0;
      end else if (run < 100000) begin
        run++;
      end
      flip = 1'b1;
      for (int j = 0; j < D; j++) begin
        int k;
        k = n - j;
        s_sw = (k >= 3) ? swq[k-3] : 1'b0;
        if (s_sw == db) flip = 1'b0;
      end
      if (flip) db = ~db;
      if (run < L) ex_state = 2'd0;
      else if (run < L + H) ex_state = 2'd1;
      else if (up_b && db_b) ex_state = 2'd3;
      else ex_state = 2'd2;
      ex_rst_n = (run >= L + H);
      ex_fetch = (ex_state == 2'd3);
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    io.pll_locked_i = 1'b1;
    io.fetch_sw_i = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      checks++;
      if (obs() !== 5'b0) begin
        errors++;
        $display("FAIL reset e%0d got %b want %b", e, obs(), 5'b0);
      end
    end
    rst = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL reset_rel e%0d got %b want %b", e, obs(), expv());
      end
    end
  endtask

  task automatic test_boot();
    int rise;
    rise = -1;
    do_reset();
    io.pll_locked_i = 1'b1;
    io.fetch_sw_i = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL boot e%0d got %b want %b", e, obs(), expv());
      end
      if (rise < 0 && io.soc_rst_n_o === 1'b1) rise = e;
    end
    checks++;
    if (rise != 2 + L + H) begin
      errors++;
      $display("FAIL boot_rise got %0d want %0d", rise, 2 + L + H);
    end
    checks++;
    if (io.boot_state_o !== 2'd2 || io.fetch_enable_o !== 1'b0) begin
      errors++;
      $display("FAIL boot_final got st=%0d fe=%b want st=2 fe=0",
               io.boot_state_o, io.fetch_enable_o);
    end
  endtask

  task automatic test_fetch();
    int rise;
    int fall;
    rise = -1;
    fall = -1;
    io.fetch_sw_i = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL fetch_up e%0d got %b want %b", e, obs(), expv());
      end
      if (rise < 0 && io.fetch_enable_o === 1'b1) rise = e;
    end
    checks++;
    if (rise != 2 + D + 1 || io.boot_state_o !== 2'd3) begin
      errors++;
      $display("FAIL fetch_rise got e%0d st=%0d want e%0d st=3",
               rise, io.boot_state_o, 2 + D + 1);
    end
    io.fetch_sw_i = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL fetch_dn e%0d got %b want %b", e, obs(), expv());
      end
      if (fall < 0 && io.fetch_enable_o === 1'b0) fall = e;
    end
    checks++;
    if (fall != 2 + D + 1 || io.soc_rst_n_o !== 1'b1) begin
      errors++;
      $display("FAIL fetch_fall got e%0d rn=%b want e%0d rn=1",
               fall, io.soc_rst_n_o, 2 + D + 1);
    end
  endtask

  task automatic test_glitch();
    int seen;
    seen = 0;
    for (int p = 0; p < 6; p++) begin
      int w;
      int g;
      w = $urandom_range(1, D - 1);
      g = $urandom_range(1, 6);
      for (int c = 0; c < w + g; c++) begin
        io.fetch_sw_i = (c < w);
        tick();
        checks++;
        if (obs() !== expv()) begin
          errors++;
          $display("FAIL glitch p%0d c%0d got %b want %b",
                   p, c, obs(), expv());
        end
        if (io.fetch_enable_o === 1'b1) seen++;
      end
    end
    for (int c = 0; c < 8; c++) tick();
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL glitch_fetch got %0d cycles want 0", seen);
    end
  endtask

  task automatic test_lock_drop();
    int rise;
    int frise;
    rise = -1;
    frise = -1;
    io.fetch_sw_i = 1'b1;
    for (int e = 1; e <= 10; e++) tick();
    checks++;
    if (io.boot_state_o !== 2'd3) begin
      errors++;
      $display("FAIL drop_pre got st=%0d want 3", io.boot_state_o);
    end
    io.pll_locked_i = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 1) io.pll_locked_i = 1'b1;
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL drop e%0d got %b want %b", e, obs(), expv());
      end
      if (e == 3) begin
        checks++;
        if (obs() !== 5'b00001) begin
          errors++;
          $display("FAIL drop_e3 got %b want %b", obs(), 5'b00001);
        end
      end
      if (e > 3 && rise < 0 && io.soc_rst_n_o === 1'b1) rise = e;
      if (e > 3 && frise < 0 && io.fetch_enable_o === 1'b1) frise = e;
    end
    checks++;
    if (rise != 1 + 2 + L + H || frise != 2 + 2 + L + H
        || io.lock_lost_o !== 1'b1) begin
      errors++;
      $display("FAIL drop_reseq got rn@%0d fe@%0d lost=%b want %0d %0d 1",
               rise, frise, io.lock_lost_o, 1 + 2 + L + H, 2 + 2 + L + H);
    end
  endtask

  task automatic test_toggle();
    int bad;
    bad = 0;
    do_reset();
    io.fetch_sw_i = 1'b0;
    for (int i = 0; i < 72; i++) begin
      io.pll_locked_i = ((i / 6) % 2 == 0);
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL toggle i%0d got %b want %b", i, obs(), expv());
      end
      if (io.boot_state_o !== 2'd0 || io.soc_rst_n_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL toggle_stay got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_rst_hold();
    int rise;
    rise = -1;
    do_reset();
    io.pll_locked_i = 1'b1;
    io.fetch_sw_i = 1'b0;
    for (int e = 1; e <= 11; e++) tick();
    checks++;
    if (io.boot_state_o !== 2'd1) begin
      errors++;
      $display("FAIL rsth_pre got st=%0d want 1", io.boot_state_o);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (obs() !== 5'b0) begin
      errors++;
      $display("FAIL rsth_clear got %b want %b", obs(), 5'b0);
    end
    for (int e = 1; e <= 18; e++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL rsth e%0d got %b want %b", e, obs(), expv());
      end
      if (rise < 0 && io.soc_rst_n_o === 1'b1) rise = e;
    end
    checks++;
    if (rise != 2 + L + H) begin
      errors++;
      $display("FAIL rsth_rise got %0d want %0d", rise, 2 + L + H);
    end
  endtask

  task automatic test_early_switch();
    int rise;
    int frise;
    rise = -1;
    frise = -1;
    do_reset();
    io.pll_locked_i = 1'b1;
    io.fetch_sw_i = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL early e%0d got %b want %b", e, obs(), expv());
      end
      if (rise < 0 && io.soc_rst_n_o === 1'b1) rise = e;
      if (frise < 0 && io.fetch_enable_o === 1'b1) frise = e;
    end
    checks++;
    if (rise != 2 + L + H || frise != 3 + L + H) begin
      errors++;
      $display("FAIL early_edges got rn@%0d fe@%0d want %0d %0d",
               rise, frise, 2 + L + H, 3 + L + H);
    end
  endtask

  task automatic test_random();
    int lseg;
    int sseg;
    lseg = 0;
    sseg = 0;
    do_reset();
    for (int c = 0; c < 900; c++) begin
      if (lseg == 0) begin
        io.pll_locked_i = ($urandom_range(0, 3) != 0);
        lseg = io.pll_locked_i ? $urandom_range(1, 40)
                               : $urandom_range(1, 4);
      end
      if (sseg == 0) begin
        io.fetch_sw_i = ~io.fetch_sw_i;
        sseg = $urandom_range(1, 12);
      end
      lseg--;
      sseg--;
      rst = ($urandom_range(0, 299) == 0);
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL random c%0d got %b want %b", c, obs(), expv());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    checks = 0;
    errors = 0;
    n = 0;
    run = 0;
    db = 1'b0;
    lost = 1'b0;
    ex_rst_n = 1'b0;
    ex_fetch = 1'b0;
    ex_state = 2'd0;
    io.pll_locked_i = 1'b0;
    io.fetch_sw_i = 1'b0;
    test_reset();
    test_boot();
    test_fetch();
    test_glitch();
    test_lock_drop();
    test_toggle();
    test_rst_hold();
    test_early_switch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
